// File: rtl/stdp_sweep_ctrl.sv
// Timestep sequencer for the sequential STDP engine: accepts spike vectors,
// sweeps all F*N pairs under the memory grant, then drains one write-back cycle.
module stdp_sweep_ctrl #(
  parameter  int F  = 48,
  parameter  int N  = 96,
  localparam int CW = $clog2(F*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ts_valid,
  output logic          ts_ready,
  input  logic [F-1:0]  ts_pre,
  input  logic [N-1:0]  ts_post,
  input  logic          learn_en,
  input  logic          mem_gnt,
  output logic          eng_enable,
  output logic [F-1:0]  eng_pre_bits,
  output logic [N-1:0]  eng_post_bits,
  output logic          mem_req,
  output logic          busy,
  output logic          sweep_done,
  output logic [CW-1:0] pair_cnt,
  output logic [15:0]   ts_count,
  output logic [15:0]   skip_count
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(F*N-1);

  state_t state;

  assign ts_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign mem_req    = (state != IDLE);
  assign sweep_done = (state == DRAIN);
  // Enable follows the grant in the same cycle so stalls cost no pair.
  assign eng_enable = (state == SWEEP) & mem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      eng_pre_bits  <= '0;
      eng_post_bits <= '0;
      pair_cnt      <= '0;
      ts_count      <= '0;
      skip_count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ts_valid) begin
            if (learn_en) begin
              eng_pre_bits  <= ts_pre;
              eng_post_bits <= ts_post;
              pair_cnt      <= '0;
              state         <= SWEEP;
            end else begin
              skip_count <= skip_count + 16'd1;
            end
          end
        end
        SWEEP: begin
          if (mem_gnt) begin
            if (pair_cnt == LAST) begin
              pair_cnt <= '0;
              state    <= DRAIN;
            end else begin
              pair_cnt <= pair_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          ts_count <= ts_count + 16'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
